// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO and sends them as start/data(LSB first)/[parity]/stop frames, one bit per CLK.
// Ports: CLK baud clock (= FIFO read clock), RST sync active-high reset,
//   FIFO_RDATA/FIFO_EMPTY/FIFO_RINC FIFO read side, PAR_EN/PAR_TYP parity enable / odd select,
//   TX_OUT serial line (idles high), BUSY high while a frame is on the line.
// Build option: define FIFO_UART_TX_PARITY_EN to build the parity bit; otherwise PAR_EN/PAR_TYP are ignored.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] FIFO_RDATA,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_RINC,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CW-1:0] cnt;
`ifdef FIFO_UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit;
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif
  // STOP may pop too, which is what lets frames run back-to-back
  assign FIFO_RINC = (state == IDLE || state == STOP) && !FIFO_EMPTY;
  // TX_OUT/BUSY are registered with the transition, so they always show the bit of the state being entered
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      TX_OUT <= 1'b1;
      BUSY   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, STOP: begin
          if (FIFO_RINC) begin
            sreg   <= FIFO_RDATA;
`ifdef FIFO_UART_TX_PARITY_EN
            par_en_q <= PAR_EN;
            par_bit  <= ^FIFO_RDATA ^ PAR_TYP;
`endif
            state  <= START;
            TX_OUT <= 1'b0;
            BUSY   <= 1'b1;
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            BUSY   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          cnt    <= '0;
          TX_OUT <= sreg[0];
          sreg   <= sreg >> 1;
        end
        DATA: begin
          if (cnt == LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state  <= par_en_q ? PARITY : STOP;
            TX_OUT <= par_en_q ? par_bit : 1'b1;
`else
            state  <= STOP;
            TX_OUT <= 1'b1;
`endif
          end else begin
            cnt    <= cnt + 1'b1;
            TX_OUT <= sreg[0];
            sreg   <= sreg >> 1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
`endif
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized and directed bench for fifo_uart_tx against a frame-queue line model.
module tb_fifo_uart_tx;
  localparam int W = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [W-1:0] FIFO_RDATA = '0;
  logic FIFO_EMPTY = 1'b1;
  logic FIFO_RINC;
  logic PAR_EN = 1'b0;
  logic PAR_TYP = 1'b0;
  logic TX_OUT;
  logic BUSY;
  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  int rinc_cnt = 0;
  logic [W-1:0] fifo[$];
  logic line[$];
  always #5 CLK = ~CLK;
  fifo_uart_tx #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .FIFO_RDATA(FIFO_RDATA), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RINC(FIFO_RINC), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .BUSY(BUSY)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // a popped word becomes its whole frame of line bits; the line shows the queue head each cycle
  task automatic push_frame(input logic [W-1:0] w, input logic pe, input logic pt);
    line.push_back(1'b0);
    for (int i = 0; i < W; i++) line.push_back(w[i]);
    if (PAR_BUILT && pe) line.push_back(^w ^ pt);
    line.push_back(1'b1);
  endtask
  task automatic step(input logic rst);
    logic exp_pop;
    RST = rst;
    FIFO_EMPTY = (fifo.size() == 0);
    FIFO_RDATA = fifo.size() > 0 ? fifo[0] : '0;
    @(negedge CLK);
    exp_pop = !FIFO_EMPTY && line.size() <= 1;
    check("tx", 32'(TX_OUT), 32'(line.size() > 0 ? line[0] : 1'b1));
    check("busy", 32'(BUSY), 32'(line.size() > 0));
    check("rinc", 32'(FIFO_RINC), 32'(exp_pop));
    busy_cnt += int'(BUSY);
    rinc_cnt += int'(FIFO_RINC);
    if (line.size() > 0) void'(line.pop_front());
    if (rst) line.delete();
    else if (exp_pop) push_frame(fifo[0], PAR_EN, PAR_TYP);
    if (FIFO_RINC && fifo.size() > 0) void'(fifo.pop_front());
    @(posedge CLK);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    #1;
    // idle after reset
    for (int i = 0; i < 20; i++) step(1'b0);
    // 0xA5 even then odd parity
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    fifo.push_back(8'hA5);
    rinc_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) step(1'b0);
    check("a5_rinc_pulses", 32'(rinc_cnt), 32'd1);
    check("a5_busy_len", 32'(busy_cnt), PAR_BUILT ? 32'd11 : 32'd10);
    PAR_TYP = 1'b1;
    fifo.push_back(8'hA5);
    for (int i = 0; i < 14; i++) step(1'b0);
    // back-to-back 0x01, 0x80 without parity
    PAR_EN = 1'b0;
    fifo.push_back(8'h01);
    fifo.push_back(8'h80);
    rinc_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 24; i++) step(1'b0);
    check("b2b_busy_len", 32'(busy_cnt), 32'd20);
    check("b2b_rinc_pulses", 32'(rinc_cnt), 32'd2);
    // reset during data bit 3 of 0xFF, next word must start cleanly
    fifo.push_back(8'hFF);
    for (int i = 0; i < 5; i++) step(1'b0);
    fifo.push_back(8'h5A);
    step(1'b1);
    for (int i = 0; i < 14; i++) step(1'b0);
    // 0x3C with PAR_EN=1 (no parity bit when the option is not built)
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    fifo.push_back(8'h3C);
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) step(1'b0);
    check("3c_busy_len", 32'(busy_cnt), PAR_BUILT ? 32'd11 : 32'd10);
    // random traffic, parity inputs toggling mid-frame, occasional bursts and resets
    for (int i = 0; i < 4000; i++) begin
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
      if ($urandom_range(0, 9) == 0 && fifo.size() < 6) fifo.push_back(W'($urandom));
      if ($urandom_range(0, 199) == 0)
        for (int k = 0; k < 4; k++) fifo.push_back(W'($urandom));
      step($urandom_range(0, 299) == 0);
    end
    fifo.delete();
    for (int i = 0; i < 15; i++) step(1'b0);
    check("final_idle_tx", 32'(TX_OUT), 32'd1);
    check("final_idle_busy", 32'(BUSY), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmitter on the read side of the asynchronous FIFO; runs in the FIFO read clock domain.
- While the FIFO reports non-empty it pops one word at a time and sends it as an asynchronous serial frame: start bit, data LSB-first, optional parity bit, stop bit.
- Pops back-to-back, so a full FIFO drains with no idle gaps between frames.
- CLK is the baud-rate tick clock, supplied by the clock divider; one bit lasts one CLK cycle.

Parameters:
- DATA_WIDTH, 8, width of a FIFO word and of the frame data field.

Ports:
- CLK  input  1  baud clock, same clock as the FIFO read clock.
- RST  input  1  synchronous reset, active-high.
- FIFO_RDATA  input  DATA_WIDTH  FIFO read data; valid whenever FIFO_EMPTY=0.
- FIFO_EMPTY  input  1  FIFO empty flag.
- FIFO_RINC  output  1  FIFO pop strobe; one-cycle pulse per word.
- PAR_EN  input  1  1 = insert parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- TX_OUT  output  1  serial line; idles high.
- BUSY  output  1  high while a frame is on the line.

Behaviour:
- Single clock CLK. Synchronous active-high reset RST. All state updates on the CLK rising edge.
- Reset values: state IDLE, TX_OUT=1, BUSY=0, FIFO_RINC=0, shift register 0, bit counter 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - If FIFO_EMPTY=0: FIFO_RINC=1 this cycle (combinational from state and FIFO_EMPTY).
  - At the edge: capture FIFO_RDATA into the shift register; latch PAR_EN, PAR_TYP and the computed parity bit; go to START.
  - If FIFO_EMPTY=1: stay in IDLE, FIFO_RINC=0.
- START: TX_OUT=0, BUSY=1; next state DATA, bit counter cleared.
- DATA:
  - TX_OUT = shift register bit 0; shift right each cycle.
  - Exactly DATA_WIDTH cycles, counter 0..DATA_WIDTH-1.
  - Last bit -> PARITY if latched PAR_EN=1, else STOP.
- PARITY:
  - TX_OUT = parity bit, one cycle, then STOP.
  - Even: XOR of data bits. Odd: inverted XOR.
- STOP:
  - TX_OUT=1, BUSY=1.
  - If FIFO_EMPTY=0: FIFO_RINC=1 and capture exactly as in IDLE; next state START (back-to-back, no idle cycle).
  - Else: next state IDLE.
- Frame length is 2 + DATA_WIDTH + latched PAR_EN cycles. BUSY is high for the whole frame and stays high across back-to-back frames.
- Latency: a word visible in IDLE puts its start bit on TX_OUT in the following cycle.
- FIFO_RINC is never asserted while FIFO_EMPTY=1. There is at most one pop per frame. No pop in START, DATA or PARITY.
- PAR_EN and PAR_TYP changes mid-frame have no effect on the frame in flight; they apply from the next capture.
- Reset mid-frame: the frame is aborted and TX_OUT=1 from the next edge. The word already popped is discarded; the FIFO is not rewound.
- FIFO_EMPTY asserted during a frame does not affect that frame.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: parity behaves as above.
- Undefined:
  - PARITY state and parity logic are not built.
  - PAR_EN and PAR_TYP ports remain but are ignored.
  - Frame is always 2 + DATA_WIDTH cycles.

Test Plan:
1. Reset then FIFO_EMPTY=1 for 20 cycles -> TX_OUT=1, BUSY=0, FIFO_RINC=0 throughout.
2. One word 0xA5, PAR_EN=1, PAR_TYP=0 -> one FIFO_RINC pulse; TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop); BUSY high for 11 cycles; then IDLE.
3. Same word with PAR_TYP=1 -> parity bit 1; otherwise identical frame.
4. Words 0x01 then 0x80 queued, PAR_EN=0 -> FIFO_RINC pulses in the IDLE cycle and in the first frame's STOP cycle; 20 consecutive BUSY cycles; TX_OUT = 0,1,0000000,1,0,0000000,1,1.
5. RST asserted during data bit 3 of 0xFF -> next cycle TX_OUT=1, BUSY=0, state IDLE; with FIFO_EMPTY=0 the next word starts cleanly, and 0xFF is not resent.
6. Macro undefined, PAR_EN=1, word 0x3C -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1 with no parity bit.
